// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment to BCD frame collector:
// segment pattern constants (bit6=a ... bit0=g, 1 = lit), the code used
// for unrecognised patterns, and the collector state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1110011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_bcd_collector_if.sv
// Handshake bundle for the collector: segment input stream with
// valid/ready, synchronous clear, and the BCD frame output with valid/ready.
// The slave modport is the collector's view, master is the environment's.
interface seg7_bcd_collector_if #(
    parameter int NDIGITS = 4
);

    logic [6:0]           seg_in;
    logic                 seg_valid;
    logic                 seg_ready;
    logic                 clear;
    logic [4*NDIGITS-1:0] bcd_out;
    logic                 bcd_err;
    logic                 bcd_valid;
    logic                 bcd_ready;

    modport master (
        output seg_in, seg_valid, clear, bcd_ready,
        input  seg_ready, bcd_out, bcd_err, bcd_valid
    );

    modport slave (
        input  seg_in, seg_valid, clear, bcd_ready,
        output seg_ready, bcd_out, bcd_err, bcd_valid
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Purely combinational lookup from a seven-segment pattern to its BCD digit.
// Anything outside the ten digit shapes (the dash included) yields the
// invalid code with digit_ok low.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_ok
);

    // Map each recognised shape to its digit; default is the invalid code.
    always_comb begin
        digit    = BCD_INVALID;
        digit_ok = 1'b0;
        case (seg_in)
            SEG_0:    begin digit = 4'd0; digit_ok = 1'b1; end
            SEG_1:    begin digit = 4'd1; digit_ok = 1'b1; end
            SEG_2:    begin digit = 4'd2; digit_ok = 1'b1; end
            SEG_3:    begin digit = 4'd3; digit_ok = 1'b1; end
            SEG_4:    begin digit = 4'd4; digit_ok = 1'b1; end
            SEG_5:    begin digit = 4'd5; digit_ok = 1'b1; end
            SEG_6:    begin digit = 4'd6; digit_ok = 1'b1; end
            SEG_7:    begin digit = 4'd7; digit_ok = 1'b1; end
            SEG_8:    begin digit = 4'd8; digit_ok = 1'b1; end
            SEG_9:    begin digit = 4'd9; digit_ok = 1'b1; end
            SEG_DASH: begin digit = BCD_INVALID; digit_ok = 1'b0; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_collector.sv
// Collects NDIGITS seven-segment patterns into one packed BCD frame,
// first digit in the most significant nibble, with a sticky error flag for
// unrecognised shapes. Define SEG7_ERR_COUNT_EN to add the saturating
// err_count port, which counts every accepted unrecognised pattern.
module seg7_bcd_collector
    import seg7_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_bcd_collector_if.slave    bus
`ifdef SEG7_ERR_COUNT_EN
    ,
    output logic [15:0]            err_count
`endif
);

    localparam int             CW       = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NDIGITS - 1);

    state_t               state;
    logic [CW-1:0]        digit_cnt;
    logic [4*NDIGITS-1:0] frame;
    logic [4*NDIGITS-1:0] frame_shifted;
    logic                 frame_err;
    logic                 ready_q;
    logic                 valid_q;
    logic [3:0]           digit;
    logic                 digit_ok;
    logic                 accept;

    seg7_pattern_decode u_decode (
        .seg_in   (bus.seg_in),
        .digit    (digit),
        .digit_ok (digit_ok)
    );

    // A pattern is taken only while collecting, ready, and not being cleared.
    assign accept = (state == ACCUM) && ready_q && bus.seg_valid && !bus.clear;

    // Next frame contents: shift older digits up one nibble, new digit enters low.
    always_comb begin
        frame_shifted      = frame << 4;
        frame_shifted[3:0] = digit;
    end

    // Collector state machine; ready/valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            digit_cnt <= '0;
            frame     <= '0;
            frame_err <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.clear) begin
            state     <= ACCUM;
            digit_cnt <= '0;
            frame     <= '0;
            frame_err <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= ACCUM;
                    ready_q <= 1'b1;
                end
                ACCUM: begin
                    if (accept) begin
                        frame     <= frame_shifted;
                        frame_err <= frame_err | ~digit_ok;
                        digit_cnt <= digit_cnt + 1'b1;
                        if (digit_cnt == LAST_IDX) begin
                            state   <= FULL;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (valid_q && bus.bcd_ready) begin
                        state     <= ACCUM;
                        digit_cnt <= '0;
                        frame     <= '0;
                        frame_err <= 1'b0;
                        ready_q   <= 1'b1;
                        valid_q   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.seg_ready = ready_q;
    assign bus.bcd_valid = valid_q;
    assign bus.bcd_out   = frame;
    assign bus.bcd_err   = frame_err;

`ifdef SEG7_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    // Lifetime count of accepted bad patterns; survives clear, saturates at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (accept && !digit_ok && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_bcd_collector.sv
// Directed self-checking bench for seg7_bcd_collector with NDIGITS=4.
// Builds with or without SEG7_ERR_COUNT_EN; the error counter checks are
// only compiled when the macro is defined.
module tb_seg7_bcd_collector;

    localparam logic [6:0] P0    = 7'b1111110;
    localparam logic [6:0] P1    = 7'b0110000;
    localparam logic [6:0] P2    = 7'b1101101;
    localparam logic [6:0] P3    = 7'b1111001;
    localparam logic [6:0] P4    = 7'b0110011;
    localparam logic [6:0] P5    = 7'b1011011;
    localparam logic [6:0] P6    = 7'b1011111;
    localparam logic [6:0] P7    = 7'b1110000;
    localparam logic [6:0] P8    = 7'b1111111;
    localparam logic [6:0] P9    = 7'b1110011;
    localparam logic [6:0] PDASH = 7'b0000001;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fail_count;

    seg7_bcd_collector_if #(.NDIGITS(4)) bus ();

`ifdef SEG7_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    seg7_bcd_collector #(.NDIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SEG7_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the sequence below.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pattern and hold it until the collector takes it.
    task automatic send(input logic [6:0] p);
        int budget;
        budget        = 0;
        bus.seg_in    = p;
        bus.seg_valid = 1'b1;
        while (bus.seg_ready !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        if (budget >= 20) begin
            tests_run++;
            fail_count++;
            $display("FAIL send_timeout: seg_ready stayed %b, required 1 within 20 cycles", bus.seg_ready);
        end
        tick();
        bus.seg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if (bus.seg_ready !== 1'b0) begin fail_count++; $display("FAIL rst_seg_ready: got %b, required 0", bus.seg_ready); end
        tests_run++; if (bus.bcd_valid !== 1'b0) begin fail_count++; $display("FAIL rst_bcd_valid: got %b, required 0", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h0000) begin fail_count++; $display("FAIL rst_bcd_out: got %h, required 0000", bus.bcd_out); end
        tests_run++; if (bus.bcd_err !== 1'b0) begin fail_count++; $display("FAIL rst_bcd_err: got %b, required 0", bus.bcd_err); end
`ifdef SEG7_ERR_COUNT_EN
        tests_run++; if (err_count !== 16'h0000) begin fail_count++; $display("FAIL rst_err_count: got %h, required 0000", err_count); end
`endif
        rst_n = 1'b1;
        #1;
        tests_run++; if (bus.seg_ready !== 1'b0) begin fail_count++; $display("FAIL rel_seg_ready_idle: got %b, required 0", bus.seg_ready); end
        tick();
        tests_run++; if (bus.seg_ready !== 1'b1) begin fail_count++; $display("FAIL rel_seg_ready_accum: got %b, required 1", bus.seg_ready); end
    endtask

    task automatic test_digits_1234();
        bus.bcd_ready = 1'b1;
        send(P1); send(P2); send(P3);
        tests_run++; if (bus.bcd_valid !== 1'b0) begin fail_count++; $display("FAIL partial_valid: got %b, required 0", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h0123) begin fail_count++; $display("FAIL partial_out: got %h, required 0123", bus.bcd_out); end
        send(P4);
        tests_run++; if (bus.bcd_valid !== 1'b1) begin fail_count++; $display("FAIL f1234_valid: got %b, required 1", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h1234) begin fail_count++; $display("FAIL f1234_out: got %h, required 1234", bus.bcd_out); end
        tests_run++; if (bus.bcd_err !== 1'b0) begin fail_count++; $display("FAIL f1234_err: got %b, required 0", bus.bcd_err); end
        tests_run++; if (bus.seg_ready !== 1'b0) begin fail_count++; $display("FAIL f1234_seg_ready: got %b, required 0", bus.seg_ready); end
        tick();
        tests_run++; if (bus.bcd_valid !== 1'b0) begin fail_count++; $display("FAIL f1234_valid_drop: got %b, required 0", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h0000) begin fail_count++; $display("FAIL f1234_out_cleared: got %h, required 0000", bus.bcd_out); end
        tests_run++; if (bus.seg_ready !== 1'b1) begin fail_count++; $display("FAIL f1234_ready_back: got %b, required 1", bus.seg_ready); end
    endtask

    task automatic test_error_frame();
        bus.bcd_ready = 1'b1;
        send(P9); send(P8); send(PDASH); send(P7);
        tests_run++; if (bus.bcd_valid !== 1'b1) begin fail_count++; $display("FAIL f98f7_valid: got %b, required 1", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h98F7) begin fail_count++; $display("FAIL f98f7_out: got %h, required 98f7", bus.bcd_out); end
        tests_run++; if (bus.bcd_err !== 1'b1) begin fail_count++; $display("FAIL f98f7_err: got %b, required 1", bus.bcd_err); end
`ifdef SEG7_ERR_COUNT_EN
        tests_run++; if (err_count !== 16'd1) begin fail_count++; $display("FAIL f98f7_err_count: got %0d, required 1", err_count); end
`endif
        tick();
        tests_run++; if (bus.bcd_err !== 1'b0) begin fail_count++; $display("FAIL f98f7_err_cleared: got %b, required 0", bus.bcd_err); end
    endtask

    task automatic test_hold_full();
        bus.bcd_ready = 1'b0;
        send(P0); send(P0); send(P0); send(P0);
        bus.seg_in    = P1;
        bus.seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (bus.bcd_valid !== 1'b1) begin fail_count++; $display("FAIL hold_valid[%0d]: got %b, required 1", i, bus.bcd_valid); end
            tests_run++; if (bus.bcd_out !== 16'h0000) begin fail_count++; $display("FAIL hold_out[%0d]: got %h, required 0000", i, bus.bcd_out); end
            tests_run++; if (bus.seg_ready !== 1'b0) begin fail_count++; $display("FAIL hold_seg_ready[%0d]: got %b, required 0", i, bus.seg_ready); end
            tick();
        end
        bus.seg_valid = 1'b0;
        bus.bcd_ready = 1'b1;
        tick();
        tests_run++; if (bus.bcd_valid !== 1'b0) begin fail_count++; $display("FAIL hold_release_valid: got %b, required 0", bus.bcd_valid); end
        tests_run++; if (bus.seg_ready !== 1'b1) begin fail_count++; $display("FAIL hold_release_ready: got %b, required 1", bus.seg_ready); end
    endtask

    task automatic test_clear();
        bus.bcd_ready = 1'b1;
        send(P1); send(P2);
        bus.seg_in    = P3;
        bus.seg_valid = 1'b1;
        bus.clear     = 1'b1;
        tick();
        bus.clear     = 1'b0;
        bus.seg_valid = 1'b0;
        tests_run++; if (bus.bcd_out !== 16'h0000) begin fail_count++; $display("FAIL clr_out: got %h, required 0000", bus.bcd_out); end
        tests_run++; if (bus.seg_ready !== 1'b1) begin fail_count++; $display("FAIL clr_seg_ready: got %b, required 1", bus.seg_ready); end
        send(P5); send(P6); send(P7);
        tests_run++; if (bus.bcd_valid !== 1'b0) begin fail_count++; $display("FAIL clr_partial_valid: got %b, required 0", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h0567) begin fail_count++; $display("FAIL clr_partial_out: got %h, required 0567", bus.bcd_out); end
        send(P8);
        tests_run++; if (bus.bcd_valid !== 1'b1) begin fail_count++; $display("FAIL f5678_valid: got %b, required 1", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h5678) begin fail_count++; $display("FAIL f5678_out: got %h, required 5678", bus.bcd_out); end
        tick();
    endtask

    task automatic test_clear_full();
        bus.bcd_ready = 1'b0;
        send(P1); send(PDASH); send(P3); send(P4);
        tests_run++; if (bus.bcd_out !== 16'h1F34) begin fail_count++; $display("FAIL f1f34_out: got %h, required 1f34", bus.bcd_out); end
        tests_run++; if (bus.bcd_err !== 1'b1) begin fail_count++; $display("FAIL f1f34_err: got %b, required 1", bus.bcd_err); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tests_run++; if (bus.bcd_valid !== 1'b0) begin fail_count++; $display("FAIL clrfull_valid: got %b, required 0", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h0000) begin fail_count++; $display("FAIL clrfull_out: got %h, required 0000", bus.bcd_out); end
        tests_run++; if (bus.bcd_err !== 1'b0) begin fail_count++; $display("FAIL clrfull_err: got %b, required 0", bus.bcd_err); end
        tests_run++; if (bus.seg_ready !== 1'b1) begin fail_count++; $display("FAIL clrfull_ready: got %b, required 1", bus.seg_ready); end
`ifdef SEG7_ERR_COUNT_EN
        tests_run++; if (err_count !== 16'd2) begin fail_count++; $display("FAIL clrfull_err_count: got %0d, required 2", err_count); end
`endif
        bus.bcd_ready = 1'b1;
    endtask

    task automatic test_reset_in_full();
        bus.bcd_ready = 1'b0;
        send(P4); send(P3); send(P2); send(P1);
        tests_run++; if (bus.bcd_out !== 16'h4321) begin fail_count++; $display("FAIL f4321_out: got %h, required 4321", bus.bcd_out); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.bcd_valid !== 1'b0) begin fail_count++; $display("FAIL rstfull_valid: got %b, required 0", bus.bcd_valid); end
        tests_run++; if (bus.bcd_out !== 16'h0000) begin fail_count++; $display("FAIL rstfull_out: got %h, required 0000", bus.bcd_out); end
        tests_run++; if (bus.seg_ready !== 1'b0) begin fail_count++; $display("FAIL rstfull_ready: got %b, required 0", bus.seg_ready); end
`ifdef SEG7_ERR_COUNT_EN
        tests_run++; if (err_count !== 16'd0) begin fail_count++; $display("FAIL rstfull_err_count: got %0d, required 0", err_count); end
`endif
        #2;
        rst_n = 1'b1;
        #1;
        tests_run++; if (bus.seg_ready !== 1'b0) begin fail_count++; $display("FAIL rstfull_rel_ready0: got %b, required 0", bus.seg_ready); end
        tick();
        tests_run++; if (bus.seg_ready !== 1'b1) begin fail_count++; $display("FAIL rstfull_rel_ready1: got %b, required 1", bus.seg_ready); end
        bus.bcd_ready = 1'b1;
    endtask

`ifdef SEG7_ERR_COUNT_EN
    task automatic test_err_saturate();
        bus.bcd_ready = 1'b1;
        bus.seg_in    = PDASH;
        bus.seg_valid = 1'b1;
        repeat (5) tick();
        tests_run++; if (err_count !== 16'd4) begin fail_count++; $display("FAIL sat_first_frame: got %0d, required 4", err_count); end
        repeat (82000) tick();
        tests_run++; if (err_count !== 16'hFFFF) begin fail_count++; $display("FAIL sat_reached: got %h, required ffff", err_count); end
        repeat (10) tick();
        tests_run++; if (err_count !== 16'hFFFF) begin fail_count++; $display("FAIL sat_holds: got %h, required ffff", err_count); end
        bus.seg_valid = 1'b0;
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        tests_run     = 0;
        fail_count    = 0;
        rst_n         = 1'b0;
        bus.seg_in    = 7'd0;
        bus.seg_valid = 1'b0;
        bus.clear     = 1'b0;
        bus.bcd_ready = 1'b0;
        test_reset();
        test_digits_1234();
        test_error_frame();
        test_hold_full();
        test_clear();
        test_clear_full();
        test_reset_in_full();
`ifdef SEG7_ERR_COUNT_EN
        test_err_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
